// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the pipelined MIPS core.
// Resolves branches and jumps, drives the dcache request and tracks LL/SC.
module mem_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc_plus_4,
    input  logic [31:0] baddr,
    input  logic [31:0] jaddr,
    input  logic [31:0] portout,
    input  logic [31:0] rdat2,
    input  logic        zero,
    input  logic        Branch,
    input  logic        bne,
    input  logic        Jump,
    input  logic        JAL,
    input  logic        MemtoReg,
    input  logic        regWEN,
    input  logic        halt,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic        datomic,
    input  logic [4:0]  wsel,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    input  logic        snoop_valid,
    input  logic [31:0] snoop_addr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] wb_wdat,
    output logic [4:0]  wb_wsel,
    output logic        wb_regWEN,
    output logic        wb_halt
);
    typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

    state_t      state, state_n;
    logic        link_valid, redirect_done;
    logic [29:0] link_addr;
    logic        live, req, taken, sc, sc_ok;
    logic        ll_done, sc_done, st_clr, snoop_clr, snoop_new;
    logic        unused_snoop_lsb;

    assign unused_snoop_lsb = &{1'b0, snoop_addr[1:0]};

    // Reset gates the request combinationally so an in-flight miss is abandoned at once
    assign live      = (state != HALT) && !RST;
    assign sc        = dWEN && datomic;
    assign sc_ok     = link_valid && (link_addr == portout[31:2]);
    assign dmemREN   = dREN && live;
    assign dmemWEN   = dWEN && live && (!datomic || sc_ok);
    assign dmemaddr  = portout;
    assign dmemstore = rdat2;
    assign req       = dmemREN || dmemWEN;
    assign mem_stall = req && !dhit;

    assign taken       = Branch && (zero ^ bne);
    assign redirect_pc = taken ? baddr : jaddr;
    assign redirect    = (taken || Jump) && !redirect_done && (state != HALT);

    assign wb_wdat   = JAL ? pc_plus_4 : sc ? {31'b0, sc_ok} : MemtoReg ? dmemload : portout;
    assign wb_wsel   = JAL ? 5'd31 : wsel;
    assign wb_regWEN = regWEN && !mem_stall && (state != HALT);

    assign ll_done   = dmemREN && datomic && dhit;
    assign sc_done   = dmemWEN && datomic && dhit;
    assign st_clr    = dmemWEN && !datomic && dhit && (portout[31:2] == link_addr);
    assign snoop_clr = snoop_valid && (snoop_addr[31:2] == link_addr);
    assign snoop_new = snoop_valid && (snoop_addr[31:2] == portout[31:2]);

    always_comb begin
        state_n = state;
        if (state == WAIT)
            state_n = dhit ? RUN : WAIT;
        else if (state == RUN)
            state_n = (req && !dhit) ? WAIT : (halt && !req) ? HALT : RUN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= RUN;
            link_valid    <= 1'b0;
            link_addr     <= '0;
            redirect_done <= 1'b0;
            wb_halt       <= 1'b0;
        end else begin
            state <= state_n;
            if (state == RUN && halt && !req)
                wb_halt <= 1'b1;
            // A redirect taken under stall must not fire again while the stage is held
            if (redirect && mem_stall)
                redirect_done <= 1'b1;
            else if (!mem_stall)
                redirect_done <= 1'b0;
            // A snoop to the word being linked wins over the LL that links it
            if (ll_done) begin
                link_addr  <= portout[31:2];
                link_valid <= !snoop_new;
            end else if (snoop_clr || sc_done || st_clr) begin
                link_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined MIPS core. It sits directly downstream of the execute/memory latch and consumes that latch's registered outputs. It resolves branches and jumps, drives the data-cache request, and implements LL/SC with a snoop-invalidated link register. It produces the write-back payload and the stall/redirect controls for the rest of the pipeline.

## Interface
- No parameters. Word width fixed at 32, register index at 5.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous reset, active-high.
- pc_plus_4, baddr, jaddr  in  32 each  from execute latch.
- portout  in  32  ALU result / memory address.
- rdat2  in  32  store data.
- zero, Branch, bne, Jump, JAL, MemtoReg, regWEN, halt  in  1 each  from execute latch.
- dREN, dWEN, datomic  in  1 each  from execute latch.
- wsel  in  5  from execute latch.
- dhit  in  1  dcache completes current request.
- dmemload  in  32  dcache read data.
- snoop_valid  in  1  another core's write is visible this cycle.
- snoop_addr  in  32  address of that write.
- dmemREN, dmemWEN  out  1 each  dcache request.
- dmemaddr, dmemstore  out  32 each  dcache request address and store data.
- mem_stall  out  1  hold all upstream latches.
- redirect  out  1  flush IF/ID/EX and load redirect_pc.
- redirect_pc  out  32  redirect target.
- wb_wdat  out  32  write-back data.
- wb_wsel  out  5  write-back register index.
- wb_regWEN  out  1  write-back enable.
- wb_halt  out  1  halt, sticky.

## Operation
- FSM states:
  - RUN → WAIT when a memory request (req = dmemREN|dmemWEN) is issued and !dhit.
  - RUN → HALT when halt=1 and req=0.
  - WAIT → RUN on dhit.
  - HALT is terminal until RST.
- dmemaddr = portout; dmemstore = rdat2.
- dmemREN = dREN & state≠HALT.
- dmemWEN = dWEN & state≠HALT & (!datomic | sc_ok).
- mem_stall = req & !dhit. It is 0 in HALT.
- taken = Branch & (zero ^ bne).
- redirect_pc = baddr if taken, else jaddr.
- redirect = (taken|Jump) & !redirect_done & state≠HALT.
  - redirect_done sets when redirect fires while mem_stall=1.
  - redirect_done clears on the first cycle mem_stall=0.
  - Each instruction therefore redirects exactly once.
- Link register (link_valid, link_addr[31:2]):
  - LL (dREN&datomic) completing with dhit sets link_valid=1 and link_addr=portout[31:2].
  - sc_ok = link_valid & link_addr==portout[31:2].
  - SC (dWEN&datomic) with sc_ok issues the write. On dhit: result 1, link_valid cleared.
  - SC with !sc_ok issues no write, result 0, completes in the same cycle with no stall.
  - A non-atomic own store completing (dhit) to link_addr clears link_valid.
  - snoop_valid with snoop_addr[31:2]==link_addr clears link_valid.
  - Snoop clear has priority over an LL set to the same word in the same cycle: link_valid ends 0.
- Write-back data select, priority order: JAL → pc_plus_4; SC → {31'b0, sc_result}; MemtoReg → dmemload; else portout.
- wb_wsel = 31 for JAL, else wsel.
- wb_regWEN = regWEN & !mem_stall & state≠HALT.
- wb_halt is registered and sticky: it sets the cycle after halt is seen in RUN and holds until RST.

## Timing
- Reset (async) values: state=RUN, link_valid=0, link_addr=0, redirect_done=0, wb_halt=0.
- All other outputs follow combinationally from those values with zeroed inputs.
- Hit latency 0: the dhit cycle completes the access, mem_stall=0, and wb_* are valid that cycle.
- Miss: mem_stall is high every cycle until the dhit cycle inclusive-exclusive, i.e. it falls in the dhit cycle.
- The execute latch drops dREN/dWEN after dhit. The stage must not re-issue while the latch is stalled by other hazards.
- RST mid-WAIT: abandons the request; dmemREN/dmemWEN fall asynchronously; link cleared.

## Test plan
- LW to 0x100, dhit after 3 cycles, dmemload=0xDEADBEEF → mem_stall=1 for 3 cycles; then wb_wdat=0xDEADBEEF, wb_regWEN=1.
- BEQ, zero=1, baddr=0x40, while a concurrent stall is active → redirect=1 on exactly one cycle, redirect_pc=0x40.
- LL 0x200 hit, then SC 0x200 → dmemWEN=1; on dhit wb_wdat=1 and link_valid=0.
- LL 0x200, then snoop_addr=0x200, then SC 0x200 → dmemWEN=0, wb_wdat=0, mem_stall=0.
- JAL with pc_plus_4=0x1C, jaddr=0x80 → redirect_pc=0x80, wb_wsel=31, wb_wdat=0x1C.
- halt=1 → next cycle wb_halt=1; later dREN=1 gives dmemREN=0. RST returns wb_halt to 0.
